// File: rtl/decode_ctrl_pipe_if.sv
// Handshake and ID/EX control bundle between the IF/ID register, the
// decode/control stage and EX.
interface decode_ctrl_pipe_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        id_ready;
  logic        ex_ready;
  logic        flush;
  logic        ex_valid;
  logic [1:0]  ex_npc_op;
  logic        ex_rf_we;
  logic        ex_alub_sel;
  logic        ex_branch;
  logic        ex_dram_we;
  logic        ex_mem2reg;
  logic        ex_j_type;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_imm_sel;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_illegal;

  // Pipeline side: presents instructions, EX backpressure and flush.
  modport master (
    output if_valid, if_instr, ex_ready, flush,
    input  id_ready, ex_valid, ex_npc_op, ex_rf_we, ex_alub_sel, ex_branch,
           ex_dram_we, ex_mem2reg, ex_j_type, ex_alu_op, ex_imm_sel,
           ex_rs1, ex_rs2, ex_rd, ex_illegal
  );

  // Decode stage side.
  modport slave (
    input  if_valid, if_instr, ex_ready, flush,
    output id_ready, ex_valid, ex_npc_op, ex_rf_we, ex_alub_sel, ex_branch,
           ex_dram_we, ex_mem2reg, ex_j_type, ex_alu_op, ex_imm_sel,
           ex_rs1, ex_rs2, ex_rd, ex_illegal
  );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// Registered RV32 decode/control stage: decodes IF/ID into the control
// bundle and registers it into ID/EX, with load-use and multiply-busy
// interlocks, EX flush and deterministic illegal decode.
//
// state | meaning
// RUN   | accepting instructions when EX is ready and no hazard/flush
// BUSY  | mul occupying EX; bubbles written while cnt counts down
//
// Register index fields are zeroed when unused: rs1/rs2 only when the
// opcode reads them, rd only when the instruction writes the register file.
module decode_ctrl_pipe #(
  parameter int EN_MEXT = 1,
  parameter int MC_LAT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  decode_ctrl_pipe_if.slave bus
);

  localparam int CW = $clog2(MC_LAT);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_BEQ = 4'b1000;
  localparam logic [3:0] ALU_BNE = 4'b1001;
  localparam logic [3:0] ALU_BLT = 4'b1010;
  localparam logic [3:0] ALU_BGE = 4'b1011;
  localparam logic [3:0] ALU_LUI = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef struct packed {
    logic       valid;
    logic [1:0] npc_op;
    logic       rf_we;
    logic       alub_sel;
    logic       branch;
    logic       dram_we;
    logic       mem2reg;
    logic       j_type;
    logic [3:0] alu_op;
    logic [2:0] imm_sel;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       illegal;
  } ctrl_t;

  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic [4:0] f_rs1;
  logic [4:0] f_rs2;
  logic [4:0] f_rd;

  ctrl_t      dec;
  ctrl_t      ex_q;
  logic       re1;
  logic       re2;
  logic       legal;
  logic       is_mul;
  logic       hazard;
  logic       accept;
  logic [0:0] state;
  logic [CW-1:0] cnt;

  assign opcode = bus.if_instr[6:0];
  assign f_rd   = bus.if_instr[11:7];
  assign func3  = bus.if_instr[14:12];
  assign f_rs1  = bus.if_instr[19:15];
  assign f_rs2  = bus.if_instr[24:20];
  assign func7  = bus.if_instr[31:25];

  // Combinational decode of the IF/ID instruction into the control bundle.
  always_comb begin
    dec    = '0;
    re1    = 1'b0;
    re2    = 1'b0;
    legal  = 1'b0;
    is_mul = 1'b0;
    case (opcode)
      OP_R: begin
        legal        = 1'b1;
        dec.rf_we    = 1'b1;
        dec.alub_sel = 1'b1;
        re1          = 1'b1;
        re2          = 1'b1;
        case ({func7, func3})
          {F7_BASE, 3'b000}: dec.alu_op = ALU_ADD;
          {F7_ALT,  3'b000}: dec.alu_op = ALU_SUB;
          {F7_BASE, 3'b001}: dec.alu_op = ALU_SLL;
          {F7_BASE, 3'b100}: dec.alu_op = ALU_XOR;
          {F7_BASE, 3'b101}: dec.alu_op = ALU_SRL;
          {F7_ALT,  3'b101}: dec.alu_op = ALU_SRA;
          {F7_BASE, 3'b110}: dec.alu_op = ALU_OR;
          {F7_BASE, 3'b111}: dec.alu_op = ALU_AND;
          {F7_MUL,  3'b000}: begin
            if (EN_MEXT != 0) begin
              dec.alu_op = ALU_MUL;
              is_mul     = 1'b1;
            end else begin
              legal = 1'b0;
            end
          end
          default: legal = 1'b0;
        endcase
      end
      OP_I: begin
        legal       = 1'b1;
        dec.rf_we   = 1'b1;
        dec.imm_sel = IMM_I;
        re1         = 1'b1;
        case (func3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            if (func7 == F7_BASE) dec.alu_op = ALU_SLL;
            else                  legal = 1'b0;
          end
          3'b101: begin
            if (func7 == F7_BASE)     dec.alu_op = ALU_SRL;
            else if (func7 == F7_ALT) dec.alu_op = ALU_SRA;
            else                      legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_LW: begin
        legal       = (func3 == 3'b010);
        dec.rf_we   = 1'b1;
        dec.mem2reg = 1'b1;
        dec.imm_sel = IMM_I;
        re1         = 1'b1;
      end
      OP_SW: begin
        legal       = (func3 == 3'b010);
        dec.dram_we = 1'b1;
        dec.imm_sel = IMM_S;
        re1         = 1'b1;
        re2         = 1'b1;
      end
      OP_BR: begin
        legal        = 1'b1;
        dec.branch   = 1'b1;
        dec.npc_op   = 2'b01;
        dec.alub_sel = 1'b1;
        dec.imm_sel  = IMM_B;
        re1          = 1'b1;
        re2          = 1'b1;
        case (func3)
          3'b000:  dec.alu_op = ALU_BEQ;
          3'b001:  dec.alu_op = ALU_BNE;
          3'b100:  dec.alu_op = ALU_BLT;
          3'b101:  dec.alu_op = ALU_BGE;
          default: legal = 1'b0;
        endcase
      end
      OP_LUI: begin
        legal       = 1'b1;
        dec.rf_we   = 1'b1;
        dec.alu_op  = ALU_LUI;
        dec.imm_sel = IMM_U;
      end
      OP_JAL: begin
        legal       = 1'b1;
        dec.rf_we   = 1'b1;
        dec.j_type  = 1'b1;
        dec.npc_op  = 2'b10;
        dec.imm_sel = IMM_J;
      end
      OP_JALR: begin
        legal       = (func3 == 3'b000);
        dec.rf_we   = 1'b1;
        dec.j_type  = 1'b1;
        dec.npc_op  = 2'b11;
        dec.imm_sel = IMM_I;
        re1         = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Illegal encodings carry no side effects and no stale fields.
    if (!legal) begin
      dec    = '0;
      re1    = 1'b0;
      re2    = 1'b0;
      is_mul = 1'b0;
    end
    dec.valid   = 1'b1;
    dec.illegal = !legal;
    dec.rs1     = re1 ? f_rs1 : 5'd0;
    dec.rs2     = re2 ? f_rs2 : 5'd0;
    dec.rd      = dec.rf_we ? f_rd : 5'd0;
  end

  // Load-use: the load in ID/EX writes a register this instruction reads.
  always_comb begin
    hazard = ex_q.valid && ex_q.mem2reg && (ex_q.rd != 5'd0) &&
             ((re1 && (f_rs1 == ex_q.rd)) || (re2 && (f_rs2 == ex_q.rd)));
  end

  assign bus.id_ready = !rst && (state == ST_RUN) && bus.ex_ready && !hazard && !bus.flush;
  assign accept       = bus.if_valid && bus.id_ready;

  // ID/EX register and RUN/BUSY sequencing; flush outranks EX backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      state <= ST_RUN;
      cnt   <= '0;
    end else if (bus.flush) begin
      ex_q  <= '0;
      state <= ST_RUN;
      cnt   <= '0;
    end else if (bus.ex_ready) begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            ex_q <= dec;
            if (is_mul) begin
              state <= ST_BUSY;
              cnt   <= CW'(MC_LAT - 1);
            end
          end else begin
            ex_q <= '0;
          end
        end
        default: begin
          ex_q <= '0;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_npc_op   = ex_q.npc_op;
  assign bus.ex_rf_we    = ex_q.rf_we;
  assign bus.ex_alub_sel = ex_q.alub_sel;
  assign bus.ex_branch   = ex_q.branch;
  assign bus.ex_dram_we  = ex_q.dram_we;
  assign bus.ex_mem2reg  = ex_q.mem2reg;
  assign bus.ex_j_type   = ex_q.j_type;
  assign bus.ex_alu_op   = ex_q.alu_op;
  assign bus.ex_imm_sel  = ex_q.imm_sel;
  assign bus.ex_rs1      = ex_q.rs1;
  assign bus.ex_rs2      = ex_q.rs2;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: directed vector table plus randomized traffic
// against a table-lookup reference model. Two instances share stimulus:
// one with the M extension (MC_LAT 3) and one without.
module tb_decode_ctrl_pipe;

  localparam int LAT   = 3;
  localparam int N_ENC = 25;
  localparam int N_TV  = 35;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4,
                 C_LUI = 5, C_JAL = 6, C_JALR = 7, C_MUL = 8;
  localparam int IDX_MUL = 8, IDX_LW = 16;

  localparam logic [31:0] ADD3   = 32'h002081B3;
  localparam logic [31:0] LW5    = 32'h0000A283;
  localparam logic [31:0] ADD655 = 32'h00528333;
  localparam logic [31:0] LW0    = 32'h0000A003;
  localparam logic [31:0] ADD600 = 32'h00000333;
  localparam logic [31:0] LUI5   = 32'h123452B7;
  localparam logic [31:0] MUL7   = 32'h022083B3;
  localparam logic [31:0] ADD8   = 32'h00208433;
  localparam logic [31:0] ILL    = 32'hFFFFFFFF;
  localparam logic [31:0] NOP    = 32'h00000013;

  typedef struct packed {
    logic       valid;
    logic [1:0] npc;
    logic       rf_we;
    logic       alub;
    logic       branch;
    logic       dram_we;
    logic       mem2reg;
    logic       j_type;
    logic [3:0] alu;
    logic [2:0] imm;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       ill;
  } ex_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         cf3;
    bit         cf7;
    logic [3:0] alu;
    int         cls;
  } enc_t;

  typedef struct {
    bit rf, alub, br, dw, m2r, j;
    logic [1:0] npc;
    logic [2:0] imm;
    bit re1, re2;
  } cls_t;

  typedef struct {
    bit rst, v;
    logic [31:0] ins;
    bit er, fl;
    bit e_rdy, e_valid;
    logic [3:0] e_alu;
    bit e_rf, e_alub, e_m2r, e_ill;
    logic [4:0] e_rd;
    bit c2, e2_valid, e2_ill, e2_rf;
    logic [4:0] e2_rd;
  } row_t;

  logic        clk = 1'b0;
  logic        t_rst = 1'b1;
  logic        t_valid = 1'b0;
  logic [31:0] t_instr = '0;
  logic        t_exrdy = 1'b1;
  logic        t_flush = 1'b0;

  int vec_count = 0;
  int err_count = 0;

  enc_t enc [N_ENC];
  cls_t cp [9];
  row_t tv [N_TV];
  ex_t  m_ex [2];
  int   m_busy [2];
  bit   en [2];
  ex_t  act1, act2;

  decode_ctrl_pipe_if bus ();
  decode_ctrl_pipe_if bus2 ();

  assign bus.if_valid  = t_valid;
  assign bus.if_instr  = t_instr;
  assign bus.ex_ready  = t_exrdy;
  assign bus.flush     = t_flush;
  assign bus2.if_valid = t_valid;
  assign bus2.if_instr = t_instr;
  assign bus2.ex_ready = t_exrdy;
  assign bus2.flush    = t_flush;

  decode_ctrl_pipe #(.EN_MEXT(1), .MC_LAT(LAT)) dut  (.clk(clk), .rst(t_rst), .bus(bus));
  decode_ctrl_pipe #(.EN_MEXT(0), .MC_LAT(LAT)) dut2 (.clk(clk), .rst(t_rst), .bus(bus2));

  assign act1 = {bus.ex_valid, bus.ex_npc_op, bus.ex_rf_we, bus.ex_alub_sel, bus.ex_branch,
                 bus.ex_dram_we, bus.ex_mem2reg, bus.ex_j_type, bus.ex_alu_op, bus.ex_imm_sel,
                 bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_illegal};
  assign act2 = {bus2.ex_valid, bus2.ex_npc_op, bus2.ex_rf_we, bus2.ex_alub_sel, bus2.ex_branch,
                 bus2.ex_dram_we, bus2.ex_mem2reg, bus2.ex_j_type, bus2.ex_alu_op, bus2.ex_imm_sel,
                 bus2.ex_rs1, bus2.ex_rs2, bus2.ex_rd, bus2.ex_illegal};

  always #5 clk = ~clk;

  task automatic put(int i, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                     bit cf3, bit cf7, logic [3:0] alu, int cls);
    enc[i] = '{op, f3, f7, cf3, cf7, alu, cls};
  endtask

  task automatic put_c(int c, bit rf, bit alub, bit br, bit dw, bit m2r, bit j,
                       logic [1:0] npc, logic [2:0] imm, bit re1, bit re2);
    cp[c] = '{rf, alub, br, dw, m2r, j, npc, imm, re1, re2};
  endtask

  function automatic row_t row(bit rst, bit v, logic [31:0] ins, bit er, bit fl, bit rdy,
                               bit ev, logic [3:0] alu, bit rf, bit alub, bit m2r, bit ill,
                               logic [4:0] rd);
    row_t r;
    r = '{rst, v, ins, er, fl, rdy, ev, alu, rf, alub, m2r, ill, rd, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    return r;
  endfunction

  // Reference decode: look the encoding up in the legal-instruction list.
  function automatic ex_t model_dec(logic [31:0] ins, bit m_en);
    ex_t  r;
    cls_t c;
    r       = '0;
    r.valid = 1'b1;
    r.ill   = 1'b1;
    for (int k = 0; k < N_ENC; k++) begin
      if (ins[6:0] == enc[k].op &&
          (!enc[k].cf3 || ins[14:12] == enc[k].f3) &&
          (!enc[k].cf7 || ins[31:25] == enc[k].f7) &&
          (enc[k].cls != C_MUL || m_en)) begin
        c         = cp[enc[k].cls];
        r.ill     = 1'b0;
        r.alu     = enc[k].alu;
        r.npc     = c.npc;
        r.rf_we   = c.rf;
        r.alub    = c.alub;
        r.branch  = c.br;
        r.dram_we = c.dw;
        r.mem2reg = c.m2r;
        r.j_type  = c.j;
        r.imm     = c.imm;
        r.rs1     = c.re1 ? ins[19:15] : 5'd0;
        r.rs2     = c.re2 ? ins[24:20] : 5'd0;
        r.rd      = c.rf  ? ins[11:7]  : 5'd0;
      end
    end
    return r;
  endfunction

  function automatic bit m_ready(int u);
    ex_t d;
    bit  hz;
    d  = model_dec(t_instr, en[u]);
    hz = m_ex[u].valid && m_ex[u].mem2reg && m_ex[u].rd != 5'd0 &&
         (d.rs1 == m_ex[u].rd || d.rs2 == m_ex[u].rd);
    return !t_rst && m_busy[u] == 0 && t_exrdy && !t_flush && !hz;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock: compare DUTs against the model mid-cycle, then advance the model.
  task automatic step();
    ex_t nx [2];
    int  nb [2];
    ex_t d;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("model id_ready u%0d t=%0t", u, $time),
          32'((u == 0) ? bus.id_ready : bus2.id_ready), 32'(m_ready(u)));
      chk($sformatf("model ex bundle u%0d t=%0t", u, $time),
          (u == 0) ? act1 : act2, m_ex[u]);
      d     = model_dec(t_instr, en[u]);
      nx[u] = m_ex[u];
      nb[u] = m_busy[u];
      if (t_rst || t_flush) begin
        nx[u] = '0;
        nb[u] = 0;
      end else if (t_exrdy) begin
        if (m_busy[u] > 0) begin
          nx[u] = '0;
          nb[u] = m_busy[u] - 1;
        end else if (t_valid && m_ready(u)) begin
          nx[u] = d;
          if (!d.ill && d.alu == 4'b1101) nb[u] = LAT - 1;
        end else begin
          nx[u] = '0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      m_ex[u]   = nx[u];
      m_busy[u] = nb[u];
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    int k;
    ins = $urandom;
    if ($urandom_range(0, 7) == 0) return ins;
    case ($urandom_range(0, 7))
      0, 1:    k = IDX_LW;
      2:       k = IDX_MUL;
      default: k = int'($urandom_range(0, N_ENC - 1));
    endcase
    ins[6:0] = enc[k].op;
    if (enc[k].cf3) ins[14:12] = enc[k].f3;
    if (enc[k].cf7) ins[31:25] = enc[k].f7;
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    en[0] = 1'b1;
    en[1] = 1'b0;

    put(0,  7'h33, 3'd0, 7'h00, 1, 1, 4'h0, C_R);
    put(1,  7'h33, 3'd0, 7'h20, 1, 1, 4'h1, C_R);
    put(2,  7'h33, 3'd1, 7'h00, 1, 1, 4'h5, C_R);
    put(3,  7'h33, 3'd4, 7'h00, 1, 1, 4'h4, C_R);
    put(4,  7'h33, 3'd5, 7'h00, 1, 1, 4'h6, C_R);
    put(5,  7'h33, 3'd5, 7'h20, 1, 1, 4'h7, C_R);
    put(6,  7'h33, 3'd6, 7'h00, 1, 1, 4'h3, C_R);
    put(7,  7'h33, 3'd7, 7'h00, 1, 1, 4'h2, C_R);
    put(8,  7'h33, 3'd0, 7'h01, 1, 1, 4'hD, C_MUL);
    put(9,  7'h13, 3'd0, 7'h00, 1, 0, 4'h0, C_I);
    put(10, 7'h13, 3'd4, 7'h00, 1, 0, 4'h4, C_I);
    put(11, 7'h13, 3'd6, 7'h00, 1, 0, 4'h3, C_I);
    put(12, 7'h13, 3'd7, 7'h00, 1, 0, 4'h2, C_I);
    put(13, 7'h13, 3'd1, 7'h00, 1, 1, 4'h5, C_I);
    put(14, 7'h13, 3'd5, 7'h00, 1, 1, 4'h6, C_I);
    put(15, 7'h13, 3'd5, 7'h20, 1, 1, 4'h7, C_I);
    put(16, 7'h03, 3'd2, 7'h00, 1, 0, 4'h0, C_LW);
    put(17, 7'h23, 3'd2, 7'h00, 1, 0, 4'h0, C_SW);
    put(18, 7'h63, 3'd0, 7'h00, 1, 0, 4'h8, C_BR);
    put(19, 7'h63, 3'd1, 7'h00, 1, 0, 4'h9, C_BR);
    put(20, 7'h63, 3'd4, 7'h00, 1, 0, 4'hA, C_BR);
    put(21, 7'h63, 3'd5, 7'h00, 1, 0, 4'hB, C_BR);
    put(22, 7'h37, 3'd0, 7'h00, 0, 0, 4'hC, C_LUI);
    put(23, 7'h6F, 3'd0, 7'h00, 0, 0, 4'h0, C_JAL);
    put(24, 7'h67, 3'd0, 7'h00, 1, 0, 4'h0, C_JALR);

    //        c       rf alub br dw m2r j  npc    imm     re1 re2
    put_c(C_R,    1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 1, 1);
    put_c(C_MUL,  1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 1, 1);
    put_c(C_I,    1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0);
    put_c(C_LW,   1, 0, 0, 0, 1, 0, 2'b00, 3'b000, 1, 0);
    put_c(C_SW,   0, 0, 0, 1, 0, 0, 2'b00, 3'b001, 1, 1);
    put_c(C_BR,   0, 1, 1, 0, 0, 0, 2'b01, 3'b010, 1, 1);
    put_c(C_LUI,  1, 0, 0, 0, 0, 0, 2'b00, 3'b011, 0, 0);
    put_c(C_JAL,  1, 0, 0, 0, 0, 1, 2'b10, 3'b100, 0, 0);
    put_c(C_JALR, 1, 0, 0, 0, 0, 1, 2'b11, 3'b000, 1, 0);

    //            rst v ins    er fl  rdy  ev alu  rf alub m2r ill rd
    tv[0]  = row(1, 1, ADD3,   1, 0,  0,   0, 4'h0, 0, 0, 0, 0, 5'd0);
    tv[1]  = row(0, 1, ADD3,   1, 0,  1,   1, 4'h0, 1, 1, 0, 0, 5'd3);
    tv[2]  = row(0, 1, LW5,    1, 0,  1,   1, 4'h0, 1, 0, 1, 0, 5'd5);
    tv[3]  = row(0, 1, ADD655, 1, 0,  0,   0, 4'h0, 0, 0, 0, 0, 5'd0);
    tv[4]  = row(0, 1, ADD655, 1, 0,  1,   1, 4'h0, 1, 1, 0, 0, 5'd6);
    tv[5]  = row(0, 1, LW0,    1, 0,  1,   1, 4'h0, 1, 0, 1, 0, 5'd0);
    tv[6]  = row(0, 1, ADD600, 1, 0,  1,   1, 4'h0, 1, 1, 0, 0, 5'd6);
    tv[7]  = row(0, 1, LW5,    1, 0,  1,   1, 4'h0, 1, 0, 1, 0, 5'd5);
    tv[8]  = row(0, 1, LUI5,   1, 0,  1,   1, 4'hC, 1, 0, 0, 0, 5'd5);
    tv[9]  = row(0, 1, MUL7,   1, 0,  1,   1, 4'hD, 1, 1, 0, 0, 5'd7);
    tv[10] = row(0, 1, ADD8,   1, 0,  0,   0, 4'h0, 0, 0, 0, 0, 5'd0);
    tv[11] = row(0, 1, ADD8,   1, 0,  0,   0, 4'h0, 0, 0, 0, 0, 5'd0);
    tv[12] = row(0, 1, ADD8,   1, 0,  1,   1, 4'h0, 1, 1, 0, 0, 5'd8);
    tv[13] = row(0, 1, MUL7,   1, 0,  1,   1, 4'hD, 1, 1, 0, 0, 5'd7);
    tv[14] = row(0, 1, ADD8,   1, 1,  0,   0, 4'h0, 0, 0, 0, 0, 5'd0);
    tv[15] = row(0, 1, ADD8,   1, 0,  1,   1, 4'h0, 1, 1, 0, 0, 5'd8);
    tv[16] = row(0, 1, LW5,    1, 0,  1,   1, 4'h0, 1, 0, 1, 0, 5'd5);
    tv[17] = row(0, 1, ADD655, 1, 1,  0,   0, 4'h0, 0, 0, 0, 0, 5'd0);
    tv[18] = row(0, 1, ADD655, 1, 0,  1,   1, 4'h0, 1, 1, 0, 0, 5'd6);
    tv[19] = row(0, 1, MUL7,   1, 0,  1,   1, 4'hD, 1, 1, 0, 0, 5'd7);
    tv[20] = row(0, 1, ADD8,   0, 0,  0,   1, 4'hD, 1, 1, 0, 0, 5'd7);
    tv[21] = row(0, 1, ADD8,   0, 0,  0,   1, 4'hD, 1, 1, 0, 0, 5'd7);
    tv[22] = row(0, 1, ADD8,   0, 0,  0,   1, 4'hD, 1, 1, 0, 0, 5'd7);
    tv[23] = row(0, 1, ADD8,   1, 0,  0,   0, 4'h0, 0, 0, 0, 0, 5'd0);
    tv[24] = row(0, 1, ADD8,   1, 0,  0,   0, 4'h0, 0, 0, 0, 0, 5'd0);
    tv[25] = row(0, 1, ADD8,   1, 0,  1,   1, 4'h0, 1, 1, 0, 0, 5'd8);
    tv[26] = row(0, 1, LW5,    1, 0,  1,   1, 4'h0, 1, 0, 1, 0, 5'd5);
    tv[27] = row(0, 1, ADD655, 0, 0,  0,   1, 4'h0, 1, 0, 1, 0, 5'd5);
    tv[28] = row(0, 1, ADD655, 1, 0,  0,   0, 4'h0, 0, 0, 0, 0, 5'd0);
    tv[29] = row(0, 1, ADD655, 1, 0,  1,   1, 4'h0, 1, 1, 0, 0, 5'd6);
    tv[30] = row(0, 1, MUL7,   1, 0,  1,   1, 4'hD, 1, 1, 0, 0, 5'd7);
    tv[31] = row(1, 1, ADD8,   1, 0,  0,   0, 4'h0, 0, 0, 0, 0, 5'd0);
    tv[32] = row(0, 1, ADD8,   1, 0,  1,   1, 4'h0, 1, 1, 0, 0, 5'd8);
    tv[33] = row(0, 1, ILL,    1, 0,  1,   1, 4'h0, 0, 0, 0, 1, 5'd0);
    tv[34] = row(0, 0, NOP,    1, 0,  1,   0, 4'h0, 0, 0, 0, 0, 5'd0);
    // Without the M extension mul is an illegal, non-blocking instruction.
    tv[9].c2  = 1; tv[9].e2_valid  = 1; tv[9].e2_ill  = 1; tv[9].e2_rf  = 0; tv[9].e2_rd  = 5'd0;
    tv[10].c2 = 1; tv[10].e2_valid = 1; tv[10].e2_ill = 0; tv[10].e2_rf = 1; tv[10].e2_rd = 5'd8;

    t_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      m_ex[u]   = '0;
      m_busy[u] = 0;
    end

    for (int i = 0; i < N_TV; i++) begin
      t_rst   = tv[i].rst;
      t_valid = tv[i].v;
      t_instr = tv[i].ins;
      t_exrdy = tv[i].er;
      t_flush = tv[i].fl;
      #2;
      chk($sformatf("row%0d id_ready", i), 32'(bus.id_ready), 32'(tv[i].e_rdy));
      step();
      chk($sformatf("row%0d ex_valid", i),    32'(bus.ex_valid),    32'(tv[i].e_valid));
      chk($sformatf("row%0d ex_alu_op", i),   32'(bus.ex_alu_op),   32'(tv[i].e_alu));
      chk($sformatf("row%0d ex_rf_we", i),    32'(bus.ex_rf_we),    32'(tv[i].e_rf));
      chk($sformatf("row%0d ex_alub_sel", i), 32'(bus.ex_alub_sel), 32'(tv[i].e_alub));
      chk($sformatf("row%0d ex_mem2reg", i),  32'(bus.ex_mem2reg),  32'(tv[i].e_m2r));
      chk($sformatf("row%0d ex_illegal", i),  32'(bus.ex_illegal),  32'(tv[i].e_ill));
      chk($sformatf("row%0d ex_rd", i),       32'(bus.ex_rd),       32'(tv[i].e_rd));
      if (tv[i].c2) begin
        chk($sformatf("row%0d nomext ex_valid", i),   32'(bus2.ex_valid),   32'(tv[i].e2_valid));
        chk($sformatf("row%0d nomext ex_illegal", i), 32'(bus2.ex_illegal), 32'(tv[i].e2_ill));
        chk($sformatf("row%0d nomext ex_rf_we", i),   32'(bus2.ex_rf_we),   32'(tv[i].e2_rf));
        chk($sformatf("row%0d nomext ex_rd", i),      32'(bus2.ex_rd),      32'(tv[i].e2_rd));
      end
    end

    for (int n = 0; n < 3000; n++) begin
      t_rst   = ($urandom_range(0, 99) == 0);
      t_flush = ($urandom_range(0, 15) == 0);
      t_exrdy = ($urandom_range(0, 4) != 0);
      t_valid = ($urandom_range(0, 3) != 0);
      t_instr = gen_instr();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
